sync_fifo_param: RTL

//  Parametrised single-clock FIFO; successor to the fixed-size RAM vector. Owns its own

---
 rtl/sync_fifo_param.sv | 103 ++++++++++
 1 files changed

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-flags and a registered read-valid strobe.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow ports.
module sync_fifo_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AF_THR     = 14,
  parameter int unsigned AE_THR     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         data_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic [CW-1:0]         w_count_nxt;
  logic [AW-1:0]         w_wr_ptr_nxt;
  logic [AW-1:0]         w_rd_ptr_nxt;

  // A push against a full FIFO is still accepted when a pop frees the slot in the same cycle.
  assign w_push_ok = push & (~full | pop);
  assign w_pop_ok  = pop & ~empty;

  assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
  assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;

  always_comb begin
    w_count_nxt = count;
    unique case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = count + 1'b1;
      2'b01:   w_count_nxt = count - 1'b1;
      default: w_count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      count        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_THR == 0);
      almost_empty <= 1'b1;
    end else begin
      data_valid <= w_pop_ok;
      if (w_push_ok) begin
        r_wr_ptr <= w_wr_ptr_nxt;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= w_rd_ptr_nxt;
        data_out <= r_mem[r_rd_ptr];
      end
      count        <= w_count_nxt;
      full         <= (w_count_nxt == CW'(DEPTH));
      empty        <= (w_count_nxt == '0);
      almost_full  <= (w_count_nxt >= CW'(AF_THR));
      almost_empty <= (w_count_nxt <= CW'(AE_THR));
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pop) overflow  <= 1'b1;
      if (pop & empty)        underflow <= 1'b1;
    end
  end
`endif

endmodule
